// File: rtl/mdu_iterative.sv
// Radix-2 iterative RISC-V M-extension multiply/divide; XLEN+2 edges normal path, 1 edge fast path.
// Valid/ready on request and result, result held until out_ready; MDU_OP_CACHE_EN adds a one-entry result cache.
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      mul_div_op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc;
  logic              neg_q, neg_r;

  logic              is_div, sgn1, sgn2, s1, s2, div0, ovf, fast, accept, hit;
  logic [XLEN-1:0]   a_abs, b_abs, fast_res;
  logic [2*XLEN-1:0] acc_init, acc_step, prod;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [XLEN-1:0]   quo, rem, res_fix;

  // Request decode: signedness, magnitudes and the early-out cases.
  always_comb begin
    is_div   = mul_div_op[2];
    sgn1     = is_div ? !mul_div_op[0] : (mul_div_op[1:0] != 2'b11);
    sgn2     = is_div ? !mul_div_op[0] : !mul_div_op[1];
    s1       = sgn1 & operand1[XLEN-1];
    s2       = sgn2 & operand2[XLEN-1];
    a_abs    = s1 ? -operand1 : operand1;
    b_abs    = s2 ? -operand2 : operand2;
    div0     = is_div && (operand2 == '0);
    ovf      = is_div && !mul_div_op[0] && (operand1 == MIN_NEG) && (operand2 == '1);
    fast     = mul_div_op[3] | div0 | ovf;
    fast_res = '0;
    if (!mul_div_op[3]) begin
      if (div0)
        fast_res = mul_div_op[1] ? operand1 : '1;
      else if (ovf)
        fast_res = mul_div_op[1] ? '0 : operand1;
    end
  end

  assign accept    = in_valid && in_ready && !flush;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

`ifdef MDU_OP_CACHE_EN
  logic [XLEN-1:0]   op1_q, op2_q, c_op1, c_op2;
  logic [2:0]        c_cls;
  logic [2*XLEN-1:0] c_raw;
  logic              c_vld;

  // MUL shares the signed-signed magnitude product with MULH.
  function automatic logic [2:0] op_class(input logic [2:0] op);
    if (op[2])
      return {2'b10, op[0]};
    return {1'b0, (op[1:0] == 2'b01) ? 2'b00 : op[1:0]};
  endfunction

  assign hit      = c_vld && (c_op1 == operand1) && (c_op2 == operand2) &&
                    (c_cls == op_class(mul_div_op[2:0]));
  assign acc_init = hit ? c_raw : {{XLEN{1'b0}}, a_abs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q <= '0;
      op2_q <= '0;
      c_op1 <= '0;
      c_op2 <= '0;
      c_cls <= '0;
      c_raw <= '0;
      c_vld <= 1'b0;
    end else begin
      if (accept) begin
        op1_q <= operand1;
        op2_q <= operand2;
      end
      if (flush)
        c_vld <= 1'b0;
      else if (state == FIX) begin
        c_vld <= 1'b1;
        c_op1 <= op1_q;
        c_op2 <= op2_q;
        c_cls <= op_class(op_q);
        c_raw <= acc;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign acc_init = {{XLEN{1'b0}}, a_abs};
`endif

  // One iteration: acc is {hi, lo} product for multiply, {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, b_q};
    if (op_q[2])
      acc_step = {diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], !diff[XLEN]};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op_q[2])
      res_fix = op_q[1] ? rem : quo;
    else
      res_fix = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)
      state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_nxt = fast ? DONE : (hit ? FIX : CALC);
        CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= '0;
      b_q    <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      Result <= '0;
    end else if (accept) begin
      op_q  <= mul_div_op[2:0];
      b_q   <= b_abs;
      neg_q <= s1 ^ s2;
      neg_r <= s1;
      cnt   <= CNT_W'(XLEN);
      acc   <= acc_init;
      if (fast)
        Result <= fast_res;
    end else if (state == CALC && !flush) begin
      acc <= acc_step;
      cnt <= cnt - CNT_W'(1);
    end else if (state == FIX && !flush) begin
      Result <= res_fix;
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vector table, flush/reset/hold sequences, random ops vs. arithmetic model.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  mul_div_op;
  logic [31:0] operand1, operand2, Result;

  int n_chk = 0;
  int n_err = 0;

  mdu_iterative #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mul_div_op(mul_div_op), .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference taken straight from the instruction definitions.
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (op[3]) return 32'h0;
    case (op[2:0])
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  function automatic int base_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[3]) return 1;
    if (op[2] && b == 0) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

`ifdef MDU_OP_CACHE_EN
  bit          c_vld = 1'b0;
  logic [31:0] c_a, c_b;
  int          c_cls;
  function automatic int cls_of(input logic [3:0] op);
    if (op[2]) return 4 + int'(op[0]);
    if (op[1:0] == 2'b01) return 0;
    return int'(op[1:0]);
  endfunction
`endif

  function automatic int adj_lat(input int base, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_OP_CACHE_EN
    if (base != 1 && c_vld && c_a == a && c_b == b && c_cls == cls_of(op)) return 2;
`endif
    return base;
  endfunction

  task automatic invalidate_model();
`ifdef MDU_OP_CACHE_EN
    c_vld = 1'b0;
`endif
  endtask

  // Issue one request, measure accept-to-out_valid edges, hold the result, then retire it.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_l, input int hold);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; mul_div_op = op; operand1 = a; operand2 = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; operand1 = $urandom; operand2 = $urandom; mul_div_op = 4'($urandom_range(0, 15));
    while (!out_valid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    chk({name, "_latency"}, 64'(lat), 64'(exp_l));
    chk({name, "_result"}, 64'(Result), 64'(exp_r));
    chk({name, "_ready_low"}, 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_result"}, 64'(Result), 64'(exp_r));
      chk({name, "_hold_valid"}, {62'd0, out_valid, in_ready}, 64'b10);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_retired"}, {62'd0, out_valid, in_ready}, 64'b01);
`ifdef MDU_OP_CACHE_EN
    if (exp_l != 1) begin c_vld = 1'b1; c_a = a; c_b = b; c_cls = cls_of(op); end
`endif
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    bit          seen;

    tbl[0]  = '{"mul",        4'b0000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 34};
    tbl[1]  = '{"mulh",       4'b0001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 34};
    tbl[2]  = '{"mulhsu",     4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    tbl[3]  = '{"mulhu",      4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    tbl[4]  = '{"div_by0",    4'b0100, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    tbl[5]  = '{"remu_by0",   4'b0111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1};
    tbl[6]  = '{"div_ovf",    4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[7]  = '{"rem_ovf",    4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    tbl[8]  = '{"div_neg",    4'b0100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    tbl[9]  = '{"rem_neg",    4'b0110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    tbl[10] = '{"divu",       4'b0101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34};
    tbl[11] = '{"remu",       4'b0111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 34};
    tbl[12] = '{"divu_minm1", 4'b0101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    tbl[13] = '{"illegal",    4'b1010, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1};
    tbl[14] = '{"rem_by0",    4'b0110, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mul_div_op = 4'h0; operand1 = '0; operand2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {28'd0, in_ready, out_valid, busy, 1'b0, Result}, {28'd0, 4'b1000, 32'h0});
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
             adj_lat(tbl[i].lat, tbl[i].op, tbl[i].a, tbl[i].b), (i == 8) ? 5 : 0);

    // Flush ten edges into a divide; a request presented alongside flush must be dropped.
    in_valid = 1'b1; mul_div_op = 4'b0100; operand1 = 32'd100; operand2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; mul_div_op = 4'b0000; operand1 = 32'd3; operand2 = 32'd4;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    invalidate_model();
    chk("flush_idle", {61'd0, in_ready, out_valid, busy}, 64'b100);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of CALC.
    in_valid = 1'b1; mul_div_op = 4'b0001; operand1 = 32'h1234_5678; operand2 = 32'h9ABC_DEF0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("calc_busy", {62'd0, busy, in_ready}, 64'b10);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {28'd0, in_ready, out_valid, busy, 1'b0, Result}, {28'd0, 4'b1000, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    invalidate_model();
    @(negedge clk);

    run_op("post_reset_mulhu", 4'b0011, 32'h8000_0001, 32'h0000_0010, 32'h0000_0008, 34, 1);

`ifdef MDU_OP_CACHE_EN
    run_op("cache_mulh", 4'b0001, 32'hDEAD_BEEF, 32'h0BAD_F00D,
           ref_res(4'b0001, 32'hDEAD_BEEF, 32'h0BAD_F00D), 34, 0);
    run_op("cache_mul", 4'b0000, 32'hDEAD_BEEF, 32'h0BAD_F00D,
           ref_res(4'b0000, 32'hDEAD_BEEF, 32'h0BAD_F00D), 2, 0);
`endif

    for (int r = 0; r < 40; r++) begin
      op = (r % 10 == 9) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       begin a = $urandom; b = 32'h0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op("random", op, a, b, ref_res(op, a, b), adj_lat(base_lat(op, a, b), op, a, b),
             int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
